// File: rtl/norm_scheduler_pkg.sv
// norm_pkg: shared FSM states, result sizing and result record for the normalization scheduler
package norm_pkg;
  typedef enum logic {ACTIVE, DRAIN} state_t;
  localparam int NORM_DW = 4;
  localparam int NORM_QW = 2*NORM_DW + 2;
  typedef struct packed {
    logic [4*NORM_QW-1:0] q;
    logic                 zero;
  } norm_result_t;
  function automatic int norm_qw(input int dw);
    return 2*dw + 2;
  endfunction
endpackage

// File: rtl/norm_result_fifo.sv
// norm_result_fifo: synchronous FIFO with extra-MSB pointer wrap and the head entry shown on dout
module norm_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) & (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  // storage and pointers; push into a full FIFO is only accepted alongside a pop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/norm_scheduler.sv
// norm_scheduler: credit-based issue, zero flagging and in-order result buffering for the normalization datapath
module norm_scheduler
  import norm_pkg::*;
#(
  parameter int DATAWIDTH  = 4,
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [4*DATAWIDTH-1:0]            s_data,
  output logic                              dp_valid,
  output logic [4*DATAWIDTH-1:0]            dp_data,
  input  logic                              dp_o_valid,
  input  logic [4*(2*DATAWIDTH+2)-1:0]      dp_q,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [4*(2*DATAWIDTH+2)-1:0]      m_data,
  output logic                              m_zero,
  input  logic                              i_flush,
  output logic                              o_flush_done,
  output logic                              o_busy,
  output logic                              o_err
);
  localparam int QW = norm_qw(DATAWIDTH);
  localparam int RW = 4*QW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int MW = $clog2(LATENCY + 1);
  localparam logic [CW:0] CAP = (CW+1)'(FIFO_DEPTH);
  state_t state, state_nx;
  logic [CW-1:0] in_flight, fifo_count;
  logic [MW-1:0] mask;
  logic s_fire, m_fire, dp_seen, ret, idle, z_head;
  logic [RW:0] res_in, res_out;
  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;
  assign dp_seen = dp_o_valid & (mask == '0);
  assign ret = dp_seen & (in_flight != '0);
  assign idle = (in_flight == '0) & (fifo_count == '0);
  assign s_ready = (state == ACTIVE) & (({1'b0, in_flight} + {1'b0, fifo_count}) < CAP);
  assign m_valid = fifo_count != '0;
  assign o_busy = ~idle;
  assign res_in = {z_head ? '0 : dp_q, z_head};
  assign m_data = res_out[RW:1];
  assign m_zero = res_out[0];
  // credit and occupancy counters plus sticky error on results with nothing outstanding
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      in_flight <= '0;
      fifo_count <= '0;
      o_err <= 1'b0;
    end else begin
      in_flight <= in_flight + CW'(s_fire) - CW'(ret);
      fifo_count <= fifo_count + CW'(ret) - CW'(m_fire);
      if (dp_seen & (in_flight == '0)) o_err <= 1'b1;
    end
  // ignore results still emerging from the datapath for LATENCY cycles after reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) mask <= MW'(LATENCY);
    else if (mask != '0) mask <= mask - 1'b1;
  // issue register feeding the non-stallable datapath
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dp_valid <= 1'b0;
      dp_data <= '0;
    end else begin
      dp_valid <= s_fire;
      if (s_fire) dp_data <= s_data;
    end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ACTIVE;
    else state <= state_nx;
  // drain sequencing: completion pulses once everything in flight and queued is gone
  always_comb begin
    state_nx = state;
    o_flush_done = 1'b0;
    if (state == ACTIVE) state_nx = i_flush ? DRAIN : ACTIVE;
    else if (idle) begin
      state_nx = ACTIVE;
      o_flush_done = 1'b1;
    end
  end
  norm_result_fifo #(.WIDTH(RW+1), .DEPTH(FIFO_DEPTH)) u_res (
    .clk(clk), .rst(rst), .push(ret), .din(res_in), .pop(m_fire), .dout(res_out)
  );
  norm_result_fifo #(.WIDTH(1), .DEPTH(FIFO_DEPTH)) u_zf (
    .clk(clk), .rst(rst), .push(s_fire), .din(s_data == '0), .pop(ret), .dout(z_head)
  );
endmodule

// File: tb/tb_norm_scheduler.sv
// tb_norm_scheduler: directed table vectors plus multi-cycle sequences against a behavioural datapath
module tb_norm_scheduler;
  import norm_pkg::*;
  localparam int DW = 4;
  localparam int LAT = 5;
  localparam int FD = 8;
  localparam int QW = 2*DW + 2;
  typedef struct packed {
    logic [4*DW-1:0] vec;
    norm_result_t    r;
  } tv_t;
  logic clk = 1'b0, rst = 1'b0, s_valid = 1'b0, m_ready = 1'b1, i_flush = 1'b0, inj = 1'b0;
  logic [4*DW-1:0] s_data = '0;
  logic s_ready, dp_valid, dp_o_valid, m_valid, m_zero, o_flush_done, o_busy, o_err;
  logic [4*DW-1:0] dp_data;
  logic [4*QW-1:0] dp_q, m_data;
  logic [LAT-1:0] pv = '0;
  logic [4*DW-1:0] pd [LAT];
  tv_t tbl [8];
  norm_result_t expq [$];
  int checks = 0, errors = 0;

  norm_scheduler #(.DATAWIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dp_valid(dp_valid), .dp_data(dp_data), .dp_o_valid(dp_o_valid), .dp_q(dp_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_zero(m_zero),
    .i_flush(i_flush), .o_flush_done(o_flush_done), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4*QW-1:0] dp_model(input logic [4*DW-1:0] v);
    int e [4];
    int s, r;
    logic [4*QW-1:0] q;
    s = 0;
    r = 0;
    q = '0;
    for (int i = 0; i < 4; i++) begin
      e[i] = int'(v[4*DW-1-DW*i -: DW]);
      s += e[i]*e[i];
    end
    while ((r+1)*(r+1) <= s) r++;
    for (int i = 0; i < 4; i++) q[4*QW-1-QW*i -: QW] = (r == 0) ? '1 : QW'((e[i]*16)/r);
    return q;
  endfunction

  // datapath stand-in: fixed latency, never stalls, keeps running through DUT reset
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], dp_valid};
    pd[0] <= dp_data;
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign dp_o_valid = pv[LAT-1] | inj;
  assign dp_q = dp_model(pd[LAT-1]);

  function automatic tv_t mk(input int a, b, c, d, qa, qb, qc, qd, input logic z);
    tv_t t;
    t.vec = {DW'(a), DW'(b), DW'(c), DW'(d)};
    t.r.q = {QW'(qa), QW'(qb), QW'(qc), QW'(qd)};
    t.r.zero = z;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_head();
    norm_result_t e;
    if (m_valid && m_ready) begin
      if (expq.size() == 0) chk("unexpected_m_valid", 1, 0);
      else begin
        e = expq.pop_front();
        chk("sb_m_data", m_data, e.q);
        chk("sb_m_zero", m_zero, e.zero);
      end
    end
  endtask

  task automatic collect(input int n);
    int got, cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        check_head();
        got++;
      end
    end
    if (got < n) chk("collect_timeout", got, n);
  endtask

  task automatic send_one(input int k);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = tbl[k].vec;
    chk("s_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("dp_valid", dp_valid, 1);
    chk("dp_data", dp_data, tbl[k].vec);
    n = 1;
    while (!m_valid && n < 4*LAT) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, LAT+2);
    chk("m_data", m_data, tbl[k].r.q);
    chk("m_zero", m_zero, tbl[k].r.zero);
    @(negedge clk);
    chk("m_valid_after_pop", m_valid, 0);
    chk("dp_data_hold", dp_data, tbl[k].vec);
  endtask

  initial begin
    int acc;
    tbl[0] = mk(3, 4, 0, 0, 9, 12, 0, 0, 1'b0);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    tbl[2] = mk(1, 0, 0, 0, 16, 0, 0, 0, 1'b0);
    tbl[3] = mk(2, 2, 2, 2, 8, 8, 8, 8, 1'b0);
    tbl[4] = mk(15, 0, 0, 0, 16, 0, 0, 0, 1'b0);
    tbl[5] = mk(1, 1, 1, 1, 8, 8, 8, 8, 1'b0);
    tbl[6] = mk(0, 0, 0, 5, 0, 0, 0, 16, 1'b0);
    tbl[7] = mk(6, 8, 0, 0, 9, 12, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_o_busy", o_busy, 0);
    chk("rst_o_err", o_err, 0);
    chk("rst_flush_done", o_flush_done, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", s_ready, 1);
    for (int k = 0; k < 8; k++) send_one(k);

    m_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = tbl[k%8].vec;
      if (s_ready) begin
        acc++;
        expq.push_back(tbl[k%8].r);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("bp_accepted", acc, FD);
    chk("bp_s_ready_low", s_ready, 0);
    repeat (10) @(negedge clk);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_s_ready_full", s_ready, 0);
    chk("bp_busy", o_busy, 1);
    m_ready = 1'b1;
    chk("bp_s_ready_at_fire", s_ready, 0);
    check_head();
    @(negedge clk);
    chk("bp_s_ready_rise", s_ready, 1);
    check_head();
    collect(6);
    @(negedge clk);
    chk("bp_drained", m_valid, 0);
    chk("bp_sb_empty", expq.size(), 0);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = tbl[k+3].vec;
      chk("fl_s_ready", s_ready, 1);
      expq.push_back(tbl[k+3].r);
    end
    @(negedge clk);
    s_valid = 1'b0;
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("fl_s_ready_low", s_ready, 0);
    chk("fl_busy", o_busy, 1);
    chk("fl_done_early", o_flush_done, 0);
    collect(3);
    chk("fl_done_at_last_fire", o_flush_done, 0);
    @(negedge clk);
    chk("fl_done_pulse", o_flush_done, 1);
    chk("fl_s_ready_drain", s_ready, 0);
    @(negedge clk);
    chk("fl_done_clear", o_flush_done, 0);
    chk("fl_active", s_ready, 1);

    chk("sp_err_before", o_err, 0);
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("sp_err_set", o_err, 1);
    chk("sp_no_m_valid", m_valid, 0);
    repeat (3) @(negedge clk);
    chk("sp_err_sticky", o_err, 1);
    chk("sp_no_m_valid_late", m_valid, 0);
    chk("sp_not_busy", o_busy, 0);

    m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = tbl[k+2].vec;
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("rs_queued", m_valid, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = tbl[k+4].vec;
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rs_m_valid", m_valid, 0);
    chk("rs_dp_valid", dp_valid, 0);
    chk("rs_dp_data", dp_data, 0);
    chk("rs_busy", o_busy, 0);
    chk("rs_err", o_err, 0);
    chk("rs_m_zero", m_zero, 0);
    chk("rs_flush_done", o_flush_done, 0);
    @(negedge clk);
    rst = 1'b1;
    m_ready = 1'b1;
    expq.delete();
    chk("rs_s_ready", s_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rs_stale_m_valid", m_valid, 0);
      chk("rs_stale_err", o_err, 0);
    end
    send_one(0);
    send_one(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/norm_scheduler.md
# norm_scheduler

Issue and flow-control controller for the 4-lane vector normalization datapath (square → adder tree → sqrt → divide). It accepts {A,B,C,D} vectors over a valid/ready handshake and issues them into the non-stallable datapath. A credit counter bounds in-flight work, and in-order results are buffered in an output FIFO so downstream backpressure never drops a result. It also flags all-zero vectors, whose sqrt is 0 and which would otherwise divide by zero, and provides a drain/flush sequence.

## Interface
Parameters:
- DATAWIDTH, 4: input element width.
- LATENCY, 5: datapath cycles from dp_valid to dp_o_valid (MUL+ADDT+SQRT+DIV stages).
- FIFO_DEPTH, 8: result FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  upstream vector valid.
- s_ready  out  1  upstream ready.
- s_data  in  4*DATAWIDTH  {A,B,C,D}, A in MSBs.
- dp_valid  out  1  issue strobe to datapath i_valid.
- dp_data  out  4*DATAWIDTH  registered {A,B,C,D} to datapath.
- dp_o_valid  in  1  AND of the four divider o_valid outputs.
- dp_q  in  4*(2*DATAWIDTH+2)  {QA,QB,QC,QD} quotients.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream ready.
- m_data  out  4*(2*DATAWIDTH+2)  result quotients.
- m_zero  out  1  result came from an all-zero vector; m_data forced to 0.
- i_flush  in  1  request drain; level sampled while ACTIVE.
- o_flush_done  out  1  one-cycle pulse when drain completes.
- o_busy  out  1  in_flight≠0 or FIFO non-empty.
- o_err  out  1  sticky: dp_o_valid seen with in_flight==0.

## Operation
- s_fire = s_valid & s_ready. m_fire = m_valid & m_ready.
- Counters:
  - in_flight (log2(FIFO_DEPTH)+1 bits): +1 on s_fire, −1 on dp_o_valid; both in one cycle → unchanged.
  - fifo_count: +1 on FIFO push, −1 on m_fire.
- s_ready = (state==ACTIVE) & (in_flight + fifo_count < FIFO_DEPTH), computed combinationally from registered state.
  - This guarantees FIFO capacity for every issued vector, so the FIFO can never overflow.
- Issue: on s_fire, dp_data ← s_data and dp_valid ← 1 next cycle; otherwise dp_valid ← 0. dp_data holds its value when idle.
- Zero tracking:
  - On s_fire, push zflag = (s_data==0) into a side FIFO of depth FIFO_DEPTH.
  - On dp_o_valid, pop it. Results return in order, so no tag is needed.
- Retire: on dp_o_valid with in_flight>0, push {zflag ? 0 : dp_q, zflag} into the result FIFO.
- Spurious result: if dp_o_valid arrives with in_flight==0, set o_err, drop the data, and leave the counters unchanged.
- FIFO output: m_valid = fifo_count≠0; m_data/m_zero show the head entry; pop on m_fire. Push and pop in the same cycle are allowed, including when full, since push only happens with a reserved slot.
- FSM (enum in package):
  - ACTIVE → DRAIN when i_flush=1.
  - DRAIN: s_ready=0. → ACTIVE when in_flight==0 & fifo_count==0; that cycle asserts o_flush_done=1.
  - i_flush held high after completion re-enters DRAIN on the next cycle.
- Reset (rst=0, async):
  - state=ACTIVE; counters 0; FIFOs empty; dp_valid=0; dp_data=0.
  - s_ready=1 after release; m_valid=0; m_zero=0; o_flush_done=0; o_busy=0; o_err=0.
  - Results still inside the datapath across reset are dropped and must not set o_err. A post-reset mask counter ignores dp_o_valid for LATENCY cycles.

## Timing
- s_fire at edge t → dp_valid high in cycle t+1 → dp_o_valid in cycle t+1+LATENCY → m_valid earliest in cycle t+2+LATENCY.
  - Total: LATENCY+2 cycles from acceptance to output.
- Throughput: 1 vector/cycle while m_ready=1.
- With m_ready=0, s_ready falls in the cycle after in_flight+fifo_count reaches FIFO_DEPTH. At most FIFO_DEPTH vectors are outstanding.
- s_ready reacts to m_fire one cycle later (counter-based; no combinational ready→ready path).
- DRAIN completion is detected in the cycle the last m_fire empties the FIFO. o_flush_done and the return to ACTIVE occur on the next edge.

## Structure
- Package norm_pkg:
  - state enum {ACTIVE, DRAIN}.
  - QW = 2*DATAWIDTH+2 and the packed result struct {logic [4*QW-1:0] q; logic zero}.
- Sub-module norm_result_fifo: synchronous, parameterized width/depth, pointer wrap with an extra MSB.
  - Instantiated twice: the result FIFO, and the zflag side FIFO at width 1.
- The top-level holds counters, FSM, issue register and reset mask.

## Test plan
- DATAWIDTH=4, FRAC_BITS=4: send {3,4,0,0} → m_data QA=9, QB=12, QC=QD=0, m_zero=0, exactly 7 cycles after s_fire.
- Send {0,0,0,0} → m_data=0, m_zero=1.
- Hold m_ready=0 and stream 12 vectors → exactly 8 accepted, s_ready=0. Release m_ready → all results in order with none lost; s_ready re-rises one cycle after the first m_fire.
- Assert i_flush mid-stream with 3 in flight → s_ready=0 immediately. o_flush_done pulses one cycle after the last m_fire; state returns to ACTIVE.
- Inject dp_o_valid with nothing issued → o_err=1 and stays set; no m_valid.
- Pull rst low with 4 in flight and 2 queued → all outputs at reset values. The stale dp_o_valid pulses afterwards produce no output and no o_err.
